// File: rtl/seg_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_frame_writer                                                |
// | Purpose  : encodes decoded Morse characters into a scrolling 8-digit,     |
// |            64-bit 7-segment frame with clear and backspace support.       |
// | Options  : SEG_CURSOR_BLINK_EN - blinking cursor on the dp of digit 0      |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module seg_frame_writer #(
  parameter int SCROLL    = 1,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [5:0]  char_code,
  output logic        char_ready,
  input  logic        clr,
  input  logic        bksp,
  output logic [63:0] seg_frame,
  output logic [3:0]  char_count,
  output logic        ovf
);

  localparam logic [3:0] c_MAX_DIGITS = 4'd8;

  logic [63:0] r_frame;
  logic [3:0]  r_count;
  logic        r_ovf;
  logic        w_full;
  logic        w_accept;
  logic [7:0]  w_glyph;

  // Segment order a,b,c,d,e,f,g,dp from bit 7 down; dp is never lit by the font.
  function automatic logic [7:0] font(input logic [5:0] code);
    logic [7:0] seg;
    case (code)
      6'd0:  seg = 8'hFC;
      6'd1:  seg = 8'h60;
      6'd2:  seg = 8'hDA;
      6'd3:  seg = 8'hF2;
      6'd4:  seg = 8'h66;
      6'd5:  seg = 8'hB6;
      6'd6:  seg = 8'hBE;
      6'd7:  seg = 8'hE0;
      6'd8:  seg = 8'hFE;
      6'd9:  seg = 8'hF6;
      6'd10: seg = 8'hEE;
      6'd11: seg = 8'h3E;
      6'd12: seg = 8'h9C;
      6'd13: seg = 8'h7A;
      6'd14: seg = 8'h9E;
      6'd15: seg = 8'h8E;
      6'd16: seg = 8'hBC;
      6'd17: seg = 8'h6E;
      6'd18: seg = 8'h0C;
      6'd19: seg = 8'h78;
      6'd20: seg = 8'hAE;
      6'd21: seg = 8'h1C;
      6'd22: seg = 8'hA8;
      6'd23: seg = 8'h2A;
      6'd24: seg = 8'h3A;
      6'd25: seg = 8'hCE;
      6'd26: seg = 8'hE6;
      6'd27: seg = 8'h0A;
      6'd28: seg = 8'hB6;
      6'd29: seg = 8'h1E;
      6'd30: seg = 8'h7C;
      6'd31: seg = 8'h38;
      6'd32: seg = 8'h54;
      6'd33: seg = 8'h6C;
      6'd34: seg = 8'h76;
      6'd35: seg = 8'hDA;
      6'd36: seg = 8'h00;
      default: seg = 8'h02;
    endcase
    return seg;
  endfunction

  assign w_glyph    = font(char_code);
  assign w_full     = (r_count == c_MAX_DIGITS);
  assign char_ready = ~clr & ~bksp & ((SCROLL != 0) | ~w_full);
  assign w_accept   = char_valid & char_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= 64'h0;
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_frame <= 64'h0;
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
    end else if (bksp) begin
      if (r_count != 4'd0) begin
        r_frame <= {8'h00, r_frame[63:8]};
        r_count <= r_count - 4'd1;
      end
    end else if (w_accept) begin
      r_frame <= {r_frame[55:0], w_glyph};
      // A full display only accepts when scrolling; the oldest digit falls off.
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + 4'd1;
      end
    end
  end

  assign char_count = r_count;
  assign ovf        = r_ovf;

  if (BLINK_DIV < 1) begin : g_blink_div_invalid
  end

`ifdef SEG_CURSOR_BLINK_EN
  localparam int            c_CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_DIV - 1);

  logic [c_CNT_W-1:0] r_blink_cnt;
  logic               r_phase;

  // Any edit restarts the blink with the cursor lit so it appears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (clr | bksp | w_accept) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == c_CNT_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign seg_frame = {r_frame[63:1], r_phase};
`else
  assign seg_frame = r_frame;
`endif

endmodule
`default_nettype wire
